// File: rtl/rv32ima_pkg.sv
// -----------------------------------------------------------------------------
// rv32ima_pkg
// Shared types and constants for the rv32ima memory-side logic.
//   mem_ctrl_state_t : mem_ctrl FSM states (IDLE, ACCESS, WAIT, RESP)
//   mem_req_kind_t   : latched request kind (fetch, data read, data write)
//   LDST_*           : load/store width encodings carried on dmem_width
// -----------------------------------------------------------------------------
package rv32ima_pkg;

    localparam int LDST_WIDTH_W = 2;

    localparam logic [1:0] LDST_BYTE = 2'b00;
    localparam logic [1:0] LDST_HALF = 2'b01;
    localparam logic [1:0] LDST_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } mem_ctrl_state_t;

    typedef enum logic [1:0] {
        REQ_I  = 2'd0,
        REQ_DR = 2'd1,
        REQ_DW = 2'd2
    } mem_req_kind_t;

endpackage

// File: rtl/ldst_lane_align.sv
// -----------------------------------------------------------------------------
// ldst_lane_align
// Purely combinational byte-lane steering between LSB-justified datapath
// values and the 32-bit RAM word.
//   width      in  : LDST_BYTE / LDST_HALF / LDST_WORD (2'b11 behaves as word)
//   offset     in  : byte address [1:0]
//   store_data in  : LSB-justified store value
//   rdata      in  : raw RAM read word
//   be         out : write byte enables; lanes past byte 3 are dropped
//   wdata      out : lane-replicated store data
//   load_data  out : rdata shifted down by offset bytes, upper bits raw
//   misalign   out : width 11, odd half offset, or word with offset != 0
// -----------------------------------------------------------------------------
module ldst_lane_align
    import rv32ima_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [2:0] n_bytes;

    always_comb begin
        n_bytes = 3'd4;
        wdata   = store_data;
        case (width)
            LDST_BYTE: begin
                n_bytes = 3'd1;
                wdata   = {4{store_data[7:0]}};
            end
            LDST_HALF: begin
                n_bytes = 3'd2;
                wdata   = {2{store_data[15:0]}};
            end
            default: begin
                n_bytes = 3'd4;
                wdata   = store_data;
            end
        endcase
    end

    // A lane is enabled when it falls inside [offset, offset+n_bytes); the
    // window never wraps, so misaligned accesses simply lose their top lanes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign be[gi] = (3'(gi) >= {1'b0, offset}) &&
                        (3'(gi) <  ({1'b0, offset} + n_bytes));
    end

    assign load_data = rdata >> {offset, 3'b000};

    assign misalign = (width == 2'b11) ||
                      ((width == LDST_HALF) && offset[0]) ||
                      ((width == LDST_WORD) && (offset != 2'b00));

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Serializes level-held fetch / load / store requests onto one single-port
// RAM with a fixed read latency. Data requests win over fetches.
// Optional feature macro: MEM_CTRL_MISALIGN_SKIP_EN -- misaligned data
// requests skip the RAM and complete with dhit one cycle after IDLE.
//   clk, rst                 : clock, asynchronous active-high reset
//   imem_ren/addr -> ihit, imem_load : fetch port
//   dmem_ren/wen/addr/width/store -> dhit, dmem_load : data port
//   ram_addr/ren/wen/be/wdata, ram_rdata : backing RAM port
// -----------------------------------------------------------------------------
module mem_ctrl
    import rv32ima_pkg::*;
#(
    parameter int RAM_LAT = 1,
    parameter int RAM_AW  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    imem_ren,
    input  logic [31:0]             imem_addr,
    output logic [31:0]             imem_load,
    output logic                    ihit,
    input  logic                    dmem_ren,
    input  logic                    dmem_wen,
    input  logic [31:0]             dmem_addr,
    input  logic [LDST_WIDTH_W-1:0] dmem_width,
    input  logic [31:0]             dmem_store,
    output logic [31:0]             dmem_load,
    output logic                    dhit,
    output logic [RAM_AW-1:0]       ram_addr,
    output logic                    ram_ren,
    output logic                    ram_wen,
    output logic [3:0]              ram_be,
    output logic [31:0]             ram_wdata,
    input  logic [31:0]             ram_rdata
);

    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    mem_ctrl_state_t   state_reg;
    mem_req_kind_t     kind_reg;
    logic [1:0]        offset_reg;
    logic              skip_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ihit_reg;
    logic              dhit_reg;
    logic              ram_ren_reg;
    logic              ram_wen_reg;
    logic [RAM_AW-1:0] ram_addr_reg;
    logic [3:0]        ram_be_reg;
    logic [31:0]       ram_wdata_reg;

    logic        data_req;
    logic        any_req;
    logic        is_store;
    logic        skip_req;
    logic [31:0] req_addr;
    logic [1:0]  req_width;
    logic [1:0]  align_offset;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;
    logic        align_misalign;

    // Request arbitration: any data request (load, store or both) beats a fetch.
    assign data_req  = dmem_ren | dmem_wen;
    assign any_req   = data_req | imem_ren;
    assign is_store  = data_req & ~dmem_ren;
    assign req_addr  = data_req ? dmem_addr : imem_addr;
    assign req_width = data_req ? dmem_width[1:0] : LDST_WORD;

    // The aligner steers the incoming store while in IDLE and the latched
    // offset afterwards, so one instance serves both directions.
    assign align_offset = (state_reg == IDLE) ? req_addr[1:0] : offset_reg;

    ldst_lane_align u_align (
        .width      (req_width),
        .offset     (align_offset),
        .store_data (dmem_store),
        .rdata      (ram_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load),
        .misalign   (align_misalign)
    );

`ifdef MEM_CTRL_MISALIGN_SKIP_EN
    assign skip_req = data_req & align_misalign;
`else
    assign skip_req = 1'b0;
    logic unused_misalign;
    assign unused_misalign = align_misalign;
`endif

    if (RAM_AW < 30) begin : g_unused_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[31:RAM_AW+2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            kind_reg      <= REQ_I;
            offset_reg    <= 2'b00;
            skip_reg      <= 1'b0;
            cnt_reg       <= '0;
            ihit_reg      <= 1'b0;
            dhit_reg      <= 1'b0;
            ram_ren_reg   <= 1'b0;
            ram_wen_reg   <= 1'b0;
            ram_addr_reg  <= '0;
            ram_be_reg    <= 4'b0000;
            ram_wdata_reg <= 32'h0;
        end else begin
            // Strobes and hits are single-cycle pulses by default.
            ram_ren_reg <= 1'b0;
            ram_wen_reg <= 1'b0;
            ihit_reg    <= 1'b0;
            dhit_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        offset_reg <= req_addr[1:0];
                        kind_reg   <= !data_req ? REQ_I : (dmem_ren ? REQ_DR : REQ_DW);
                        skip_reg   <= skip_req;
                        if (skip_req) begin
                            dhit_reg  <= 1'b1;
                            state_reg <= RESP;
                        end else begin
                            ram_addr_reg <= req_addr[RAM_AW+1:2];
                            ram_ren_reg  <= ~is_store;
                            ram_wen_reg  <= is_store;
                            ram_be_reg   <= is_store ? align_be : 4'b1111;
                            if (is_store) begin
                                ram_wdata_reg <= align_wdata;
                            end
                            state_reg <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    cnt_reg <= CNT_W'(RAM_LAT - 1);
                    if (RAM_LAT == 1) begin
                        ihit_reg  <= (kind_reg == REQ_I);
                        dhit_reg  <= (kind_reg != REQ_I);
                        state_reg <= RESP;
                    end else begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    // Leaving on the 1->0 step lands RESP exactly RAM_LAT
                    // cycles after the strobe.
                    if (cnt_reg == CNT_W'(1)) begin
                        ihit_reg  <= (kind_reg == REQ_I);
                        dhit_reg  <= (kind_reg != REQ_I);
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ihit      = ihit_reg;
    assign dhit      = dhit_reg;
    assign ram_ren   = ram_ren_reg;
    assign ram_wen   = ram_wen_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_be    = ram_be_reg;
    assign ram_wdata = ram_wdata_reg;

    // Load data is taken straight from the RAM during RESP and forced to zero
    // otherwise; a skipped request has no RAM data behind it.
    assign imem_load = ihit_reg ? ram_rdata : 32'h0;
    assign dmem_load = (dhit_reg && !skip_reg) ? align_load : 32'h0;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Directed plus randomized checks of mem_ctrl. u_dut1 runs with RAM_LAT=1,
// u_dut3 with RAM_LAT=3 for the wait-state and mid-access reset cases.
// Each DUT drives a behavioural RAM; expected values come from a byte-lane
// reference memory updated with the store rules.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
    import rv32ima_pkg::*;

    localparam int K_I  = 0;
    localparam int K_DR = 1;
    localparam int K_DW = 2;

    logic clk;
    logic rst1, rst3;

    // RAM_LAT = 1 instance signals
    logic        imem_ren1, ihit1, dmem_ren1, dmem_wen1, dhit1, ram_ren1, ram_wen1;
    logic [31:0] imem_addr1, imem_load1, dmem_addr1, dmem_store1, dmem_load1;
    logic [31:0] ram_wdata1, ram_rdata1;
    logic [1:0]  dmem_width1;
    logic [13:0] ram_addr1;
    logic [3:0]  ram_be1;

    // RAM_LAT = 3 instance signals
    logic        imem_ren3, ihit3, dmem_ren3, dmem_wen3, dhit3, ram_ren3, ram_wen3;
    logic [31:0] imem_addr3, imem_load3, dmem_addr3, dmem_store3, dmem_load3;
    logic [31:0] ram_wdata3, ram_rdata3;
    logic [1:0]  dmem_width3;
    logic [13:0] ram_addr3;
    logic [3:0]  ram_be3;

    int n_checks = 0;
    int n_fail   = 0;

    mem_ctrl #(.RAM_LAT(1), .RAM_AW(14)) u_dut1 (
        .clk(clk), .rst(rst1),
        .imem_ren(imem_ren1), .imem_addr(imem_addr1), .imem_load(imem_load1), .ihit(ihit1),
        .dmem_ren(dmem_ren1), .dmem_wen(dmem_wen1), .dmem_addr(dmem_addr1),
        .dmem_width(dmem_width1), .dmem_store(dmem_store1), .dmem_load(dmem_load1), .dhit(dhit1),
        .ram_addr(ram_addr1), .ram_ren(ram_ren1), .ram_wen(ram_wen1), .ram_be(ram_be1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    mem_ctrl #(.RAM_LAT(3), .RAM_AW(14)) u_dut3 (
        .clk(clk), .rst(rst3),
        .imem_ren(imem_ren3), .imem_addr(imem_addr3), .imem_load(imem_load3), .ihit(ihit3),
        .dmem_ren(dmem_ren3), .dmem_wen(dmem_wen3), .dmem_addr(dmem_addr3),
        .dmem_width(dmem_width3), .dmem_store(dmem_store3), .dmem_load(dmem_load3), .dhit(dhit3),
        .ram_addr(ram_addr3), .ram_ren(ram_ren3), .ram_wen(ram_wen3), .ram_be(ram_be3),
        .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment: initial RAM contents ----------------
    function automatic logic [31:0] init_word(input int a);
        case (a)
            4:       return 32'h0050_0093;
            'h80:    return 32'hBEEF_1234;
            default: return (a * 32'h9E37_79B1) + 32'h0123_4567;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~m) | (new_w & m);
    endfunction

    // ---------------- behavioural RAMs ----------------
    logic [31:0] mem1 [0:16383];
    logic        written1 [0:16383];
    logic [31:0] pipe3 [0:2];

    function automatic logic [31:0] ram1_rd(input logic [13:0] a);
        return written1[a] ? mem1[a] : init_word(int'(a));
    endfunction

    always @(posedge clk) begin
        if (ram_wen1) begin
            mem1[ram_addr1]     <= merge(ram1_rd(ram_addr1), ram_wdata1, ram_be1);
            written1[ram_addr1] <= 1'b1;
        end
        ram_rdata1 <= ram_ren1 ? ram1_rd(ram_addr1) : 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        pipe3[0] <= ram_ren3 ? init_word(int'(ram_addr3)) : 32'hDEAD_BEEF;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_rdata3 = pipe3[2];

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic int n_bytes_of(input logic [1:0] w);
        return (w == LDST_BYTE) ? 1 : (w == LDST_HALF) ? 2 : 4;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] w, input logic [1:0] o);
        int n;
        n = n_bytes_of(w);
        return 4'(((1 << n) - 1) << o);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] w, input logic [31:0] s);
        if (w == LDST_BYTE) return {s[7:0], s[7:0], s[7:0], s[7:0]};
        if (w == LDST_HALF) return {s[15:0], s[15:0]};
        return s;
    endfunction

    function automatic bit is_misaligned(input logic [1:0] w, input logic [1:0] o);
        return (w == 2'b11) || (w == LDST_HALF && o[0]) || (w == LDST_WORD && o != 2'b00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One request on u_dut1, starting at a negedge with the FSM in IDLE.
    task automatic run1(input int kind, input logic [31:0] addr, input logic [1:0] w,
                        input logic [31:0] sd, input bit both, input bit drop_early);
        logic [1:0]  o;
        bit          skip;
        int          exp_lat, hit_cyc, strobe_n;
        logic [31:0] word_before, il, dl, swd;
        logic [1:0]  hits;
        logic        sr, sw;
        logic [3:0]  sbe;
        logic [13:0] sad;
        o    = addr[1:0];
        skip = 1'b0;
`ifdef MEM_CTRL_MISALIGN_SKIP_EN
        skip = (kind != K_I) && is_misaligned(w, o);
`endif
        exp_lat     = skip ? 1 : 2;
        word_before = ref_rd(int'(addr[15:2]));
        if (kind == K_I) begin
            imem_ren1 = 1'b1; imem_addr1 = addr;
        end else begin
            dmem_ren1 = (kind == K_DR); dmem_wen1 = (kind == K_DW) || both;
            dmem_addr1 = addr; dmem_width1 = w; dmem_store1 = sd;
        end
        hit_cyc = 0; strobe_n = 0; hits = 2'b00; il = 0; dl = 0;
        sr = 0; sw = 0; sbe = 0; swd = 0; sad = 0;
        for (int cyc = 1; cyc <= 8 && hit_cyc == 0; cyc++) begin
            @(negedge clk);
            if (ram_ren1 || ram_wen1) begin
                strobe_n++; sr = ram_ren1; sw = ram_wen1; sbe = ram_be1; swd = ram_wdata1; sad = ram_addr1;
            end
            if (ihit1 || dhit1) begin
                hit_cyc = cyc; hits = {ihit1, dhit1}; il = imem_load1; dl = dmem_load1;
                imem_ren1 = 0; dmem_ren1 = 0; dmem_wen1 = 0;
            end else if (cyc == 1 && drop_early) begin
                imem_ren1 = 0; dmem_ren1 = 0; dmem_wen1 = 0;
            end
        end
        chk("latency", hit_cyc, exp_lat);
        chk("hit_kind", 32'(hits), (kind == K_I) ? 32'd2 : 32'd1);
        chk("strobe_count", strobe_n, skip ? 0 : 1);
        if (!skip) begin
            chk("strobe_kind", {sr, sw}, (kind == K_DW) ? 32'd1 : 32'd2);
            chk("ram_addr", 32'(sad), 32'(addr[15:2]));
            chk("ram_be", 32'(sbe), (kind == K_DW) ? 32'(exp_be(w, o)) : 32'hF);
            if (kind == K_DW) chk("ram_wdata", swd, exp_wd(w, sd));
        end
        if (kind == K_I)  chk("imem_load", il, word_before);
        if (kind == K_DR) chk("dmem_load", dl, skip ? 32'h0 : (word_before >> (8 * o)));
        if (kind == K_DW && !skip)
            ref_mem[int'(addr[15:2])] = merge(word_before, exp_wd(w, sd), exp_be(w, o));
        @(negedge clk);
        chk("hit_pulse", {ihit1, dhit1}, 0);
        chk("load_idle_zero", imem_load1 | dmem_load1, 0);
        $display("txn kind=%0d addr=0x%08h width=%0d store=0x%08h hit_cyc=%0d", kind, addr, w, sd, hit_cyc);
    endtask

    initial begin
        int d_cyc, i_cyc, hit_cyc;
        bit both_seen;
        logic [31:0] il, dl;

        for (int i = 0; i < 16384; i++) written1[i] = 1'b0;
        rst1 = 1; rst3 = 1;
        imem_ren1 = 0; imem_addr1 = 0; dmem_ren1 = 0; dmem_wen1 = 0;
        dmem_addr1 = 0; dmem_width1 = 0; dmem_store1 = 0;
        imem_ren3 = 0; imem_addr3 = 0; dmem_ren3 = 0; dmem_wen3 = 0;
        dmem_addr3 = 0; dmem_width3 = 0; dmem_store3 = 0;

        repeat (3) @(negedge clk);
        chk("rst_hits_strobes", {ihit1, dhit1, ram_ren1, ram_wen1}, 0);
        chk("rst_ram_be", 32'(ram_be1), 0);
        chk("rst_ram_addr", 32'(ram_addr1), 0);
        chk("rst_ram_wdata", ram_wdata1, 0);
        chk("rst_loads", imem_load1 | dmem_load1, 0);
        rst1 = 0;
        @(negedge clk);

        // Directed cases
        run1(K_I,  32'h0000_0010, LDST_WORD, 32'h0, 0, 0);
        run1(K_DW, 32'h0000_0103, LDST_BYTE, 32'h0000_00A5, 0, 0);
        run1(K_DR, 32'h0000_0100, LDST_WORD, 32'h0, 0, 0);
        chk("byte_store_top", 32'(ref_rd('h40) >> 24), 32'hA5);
        run1(K_DR, 32'h0000_0202, LDST_HALF, 32'h0, 0, 0);
        run1(K_DW, 32'h0000_0101, LDST_WORD, 32'h1122_3344, 0, 0);
        run1(K_DR, 32'h0000_0110, LDST_WORD, 32'h0, 1, 0);   // ren+wen acts as load
        run1(K_DR, 32'h0000_0114, LDST_WORD, 32'h0, 0, 1);   // dropped after latch

        // Same-cycle data and fetch: data first, fetch one cycle after RESP
        dmem_ren1 = 1; dmem_wen1 = 0; dmem_addr1 = 32'h202; dmem_width1 = LDST_HALF;
        imem_ren1 = 1; imem_addr1 = 32'h10;
        d_cyc = 0; i_cyc = 0; both_seen = 0; il = 0; dl = 0;
        for (int cyc = 1; cyc <= 12 && i_cyc == 0; cyc++) begin
            @(negedge clk);
            if (ihit1 && dhit1) both_seen = 1;
            if (dhit1 && d_cyc == 0) begin d_cyc = cyc; dl = dmem_load1; dmem_ren1 = 0; end
            if (ihit1) begin i_cyc = cyc; il = imem_load1; imem_ren1 = 0; end
        end
        @(negedge clk);
        chk("prio_dhit_cyc", d_cyc, 2);
        chk("prio_ihit_cyc", i_cyc, 5);
        chk("prio_no_overlap", 32'(both_seen), 0);
        chk("prio_dmem_load", dl, ref_rd('h80) >> 16);
        chk("prio_imem_load", il, ref_rd(4));
        $display("txn same-cycle dhit_cyc=%0d ihit_cyc=%0d", d_cyc, i_cyc);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            if (kind == K_I) a = 32'h100 + 4 * $urandom_range(0, 15);
            else a = (32'h100 + $urandom_range(0, 63)) | ($urandom & 32'hFFFF_0000);
            run1(kind, a, 2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        // RAM_LAT = 3: reset while waiting, then re-serve the held request
        rst3 = 0;
        @(negedge clk);
        dmem_ren3 = 1; dmem_addr3 = 32'h202; dmem_width3 = LDST_HALF;
        @(negedge clk);
        chk("lat3_ren", 32'(ram_ren3), 1);
        @(negedge clk);
        chk("lat3_wait_nohit", {dhit3, ram_ren3}, 0);
        rst3 = 1;
        #1;
        chk("lat3_rst_hits_strobes", {ihit3, dhit3, ram_ren3, ram_wen3}, 0);
        chk("lat3_rst_ram_be", 32'(ram_be3), 0);
        chk("lat3_rst_ram_addr", 32'(ram_addr3), 0);
        chk("lat3_rst_ram_wdata", ram_wdata3, 0);
        chk("lat3_rst_loads", imem_load3 | dmem_load3, 0);
        @(negedge clk);
        rst3 = 0;
        hit_cyc = 0; dl = 0;
        for (int cyc = 1; cyc <= 10 && hit_cyc == 0; cyc++) begin
            @(negedge clk);
            if (dhit3 || ihit3) begin hit_cyc = cyc; dl = dmem_load3; dmem_ren3 = 0; end
        end
        chk("lat3_reserve_cyc", hit_cyc, 4);
        chk("lat3_reserve_data", dl, 32'h0000_BEEF);
        $display("txn lat3 reset-reserve hit_cyc=%0d load=0x%08h", hit_cyc, dl);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
